// File: rtl/button_pulse_gen_if.sv
// Button conditioning bus: raw level in; pulse, debounced level and repeat flag out.
interface button_pulse_gen_if;
    logic btn_in;
    logic pulse;
    logic pressed;
    logic repeating;

    modport master (
        output btn_in,
        input  pulse,
        input  pressed,
        input  repeating
    );

    modport slave (
        input  btn_in,
        output pulse,
        output pressed,
        output repeating
    );
endinterface

// File: rtl/button_pulse_gen.sv
// Synchronise, debounce and pulse-encode a push button for the counter enable.
// Auto-repeat is built only when BUTTON_PULSE_GEN_AUTOREPEAT_EN is defined.
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int CNT_W           = 8
) (
    input  logic                clk,
    input  logic                rst,
    button_pulse_gen_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_REPEAT,
        S_RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] D_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_btn_s;
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] w_dcnt_nxt;
    logic             w_fire;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_pressed;
    logic             w_pressed_nxt;

`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_TERM = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_TERM = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] r_rcnt;
    logic [CNT_W-1:0] w_rcnt_nxt;
    logic             r_repeating;
    logic             w_repeating_nxt;
`endif

    // State, synchroniser, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_s1        <= 1'b0;
            r_btn_s     <= 1'b0;
            r_dcnt      <= '0;
            r_pulse     <= 1'b0;
            r_pressed   <= 1'b0;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
            r_rcnt      <= '0;
            r_repeating <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_s1        <= bus.btn_in;
            r_btn_s     <= r_s1;
            r_dcnt      <= w_dcnt_nxt;
            r_pulse     <= w_pulse_nxt;
            r_pressed   <= w_pressed_nxt;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
            r_rcnt      <= w_rcnt_nxt;
            r_repeating <= w_repeating_nxt;
`endif
        end
    end

    // A level change always wins over a terminal count on the same edge
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_fire      = 1'b0;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
        w_rcnt_nxt  = r_rcnt;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_dcnt_nxt  = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_IDLE;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == D_TERM) begin
                    w_state_nxt = S_HELD;
                    w_dcnt_nxt  = '0;
                    w_fire      = 1'b1;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
                    w_rcnt_nxt  = '0;
`endif
                end else begin
                    w_dcnt_nxt  = r_dcnt + C_ONE;
                end
            end
            S_HELD: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_dcnt_nxt  = '0;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
                    w_rcnt_nxt  = '0;
                end else if (r_rcnt == DLY_TERM) begin
                    w_state_nxt = S_REPEAT;
                    w_rcnt_nxt  = '0;
                    w_fire      = 1'b1;
                end else begin
                    w_rcnt_nxt  = r_rcnt + C_ONE;
`endif
                end
            end
            S_REPEAT: begin
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
                if (!r_btn_s) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_dcnt_nxt  = '0;
                    w_rcnt_nxt  = '0;
                end else if (r_rcnt == PER_TERM) begin
                    w_rcnt_nxt  = '0;
                    w_fire      = 1'b1;
                end else begin
                    w_rcnt_nxt  = r_rcnt + C_ONE;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_RELEASE_WAIT: begin
                if (r_btn_s) begin
                    w_state_nxt = S_HELD;
                    w_dcnt_nxt  = '0;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
                    w_rcnt_nxt  = '0;
`endif
                end else if (r_dcnt == D_TERM) begin
                    w_state_nxt = S_IDLE;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt  = r_dcnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_dcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        w_pulse_nxt     = w_fire;
        w_pressed_nxt   = (w_state_nxt == S_HELD)
                       || (w_state_nxt == S_REPEAT)
                       || (w_state_nxt == S_RELEASE_WAIT);
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
        w_repeating_nxt = (w_state_nxt == S_REPEAT);
`endif
    end

    assign bus.pulse     = r_pulse;
    assign bus.pressed   = r_pressed;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
    assign bus.repeating = r_repeating;
`else
    assign bus.repeating = 1'b0;
`endif

endmodule
